// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard to ASCII source.
package kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    localparam logic [7:0] ASC_LOWER_A  = 8'h61;
    localparam logic [7:0] ASC_ZERO     = 8'h30;
    localparam logic [7:0] ASC_SPACE    = 8'h20;
    localparam logic [7:0] ASC_CASE_OFS = 8'h20;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for PS/2 clock and data plus falling-edge detect
// on the synchronized clock; all flops reset to the idle-high line level.
module ps2_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_fall,
    output logic o_data
);

    logic [1:0] r_clk_sync;
    logic [1:0] r_dat_sync;
    logic       r_clk_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_data};
            r_clk_prev <= r_clk_sync[1];
        end
    end

    assign o_fall = r_clk_prev & ~r_clk_sync[1];
    assign o_data = r_dat_sync[1];

endmodule

// File: rtl/ps2_kbd_ascii_source.sv
// PS/2 set-2 keyboard receiver and scan-code to ASCII decoder.
// Define KBD_PARITY_CHECK_EN to drop odd-parity failures and pulse parity_err.
module ps2_kbd_ascii_source
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       kbd_data_ready,
    output logic [7:0] kbd_received_ascii_code,
    output logic       parity_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic             w_fall;
    logic             w_data;
    frame_state_t     r_state;
    frame_state_t     w_state_nxt;
    logic [7:0]       r_sreg;
    logic [2:0]       r_bitcnt;
    logic [TMO_W-1:0] r_tmo;
    logic             w_frame_end;
    logic             w_byte_vld;
    logic             r_shift_held;
    logic             r_brk_pend;
    logic             r_ext_pend;
    logic [8:0]       w_lut;
    logic [7:0]       w_ascii;

    ps2_sync_edge u_sync (
        .i_clk      (clk_in),
        .i_rst_n    (reset),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .o_fall     (w_fall),
        .o_data     (w_data)
    );

    // Returns {hit, ascii}; letters come back lower case.
    function automatic logic [8:0] scan_lookup(input logic [7:0] sc);
        logic [8:0] r;
        case (sc)
            8'h1C: r = {1'b1, ASC_LOWER_A + 8'd0};
            8'h32: r = {1'b1, ASC_LOWER_A + 8'd1};
            8'h21: r = {1'b1, ASC_LOWER_A + 8'd2};
            8'h23: r = {1'b1, ASC_LOWER_A + 8'd3};
            8'h24: r = {1'b1, ASC_LOWER_A + 8'd4};
            8'h2B: r = {1'b1, ASC_LOWER_A + 8'd5};
            8'h34: r = {1'b1, ASC_LOWER_A + 8'd6};
            8'h33: r = {1'b1, ASC_LOWER_A + 8'd7};
            8'h43: r = {1'b1, ASC_LOWER_A + 8'd8};
            8'h3B: r = {1'b1, ASC_LOWER_A + 8'd9};
            8'h42: r = {1'b1, ASC_LOWER_A + 8'd10};
            8'h4B: r = {1'b1, ASC_LOWER_A + 8'd11};
            8'h3A: r = {1'b1, ASC_LOWER_A + 8'd12};
            8'h31: r = {1'b1, ASC_LOWER_A + 8'd13};
            8'h44: r = {1'b1, ASC_LOWER_A + 8'd14};
            8'h4D: r = {1'b1, ASC_LOWER_A + 8'd15};
            8'h15: r = {1'b1, ASC_LOWER_A + 8'd16};
            8'h2D: r = {1'b1, ASC_LOWER_A + 8'd17};
            8'h1B: r = {1'b1, ASC_LOWER_A + 8'd18};
            8'h2C: r = {1'b1, ASC_LOWER_A + 8'd19};
            8'h3C: r = {1'b1, ASC_LOWER_A + 8'd20};
            8'h2A: r = {1'b1, ASC_LOWER_A + 8'd21};
            8'h1D: r = {1'b1, ASC_LOWER_A + 8'd22};
            8'h22: r = {1'b1, ASC_LOWER_A + 8'd23};
            8'h35: r = {1'b1, ASC_LOWER_A + 8'd24};
            8'h1A: r = {1'b1, ASC_LOWER_A + 8'd25};
            8'h45: r = {1'b1, ASC_ZERO + 8'd0};
            8'h16: r = {1'b1, ASC_ZERO + 8'd1};
            8'h1E: r = {1'b1, ASC_ZERO + 8'd2};
            8'h26: r = {1'b1, ASC_ZERO + 8'd3};
            8'h25: r = {1'b1, ASC_ZERO + 8'd4};
            8'h2E: r = {1'b1, ASC_ZERO + 8'd5};
            8'h36: r = {1'b1, ASC_ZERO + 8'd6};
            8'h3D: r = {1'b1, ASC_ZERO + 8'd7};
            8'h3E: r = {1'b1, ASC_ZERO + 8'd8};
            8'h46: r = {1'b1, ASC_ZERO + 8'd9};
            8'h29: r = {1'b1, ASC_SPACE};
            default: r = 9'd0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A falling edge always wins over a coincident timeout expiry.
    always_comb begin
        w_state_nxt = r_state;
        if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!w_data) w_state_nxt = ST_DATA;
                ST_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP:   w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end else if (r_state != ST_IDLE && r_tmo == TMO_LAST) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_sreg   <= 8'd0;
            r_bitcnt <= 3'd0;
            r_tmo    <= '0;
        end else begin
            if (w_fall || r_state == ST_IDLE) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (r_state == ST_IDLE) begin
                r_sreg   <= 8'd0;
                r_bitcnt <= 3'd0;
            end else if (w_fall && r_state == ST_DATA) begin
                r_sreg   <= {w_data, r_sreg[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
            end
        end
    end

    assign w_frame_end = w_fall && (r_state == ST_STOP);

`ifdef KBD_PARITY_CHECK_EN
    logic r_parity;
    logic w_par_ok;

    assign w_par_ok   = ^{r_sreg, r_parity};
    assign w_byte_vld = w_frame_end && w_data && w_par_ok;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_parity   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (w_fall && r_state == ST_PARITY) r_parity <= w_data;
            parity_err <= w_frame_end && w_data && !w_par_ok;
        end
    end
`else
    assign w_byte_vld = w_frame_end && w_data;
    assign parity_err = 1'b0;
`endif

    assign w_lut   = scan_lookup(r_sreg);
    assign w_ascii = (r_shift_held && w_lut[7:0] >= ASC_LOWER_A) ?
                     (w_lut[7:0] - ASC_CASE_OFS) : w_lut[7:0];

    // Decoder: prefixes arm flags, the following byte is swallowed.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            kbd_data_ready          <= 1'b0;
            kbd_received_ascii_code <= 8'd0;
            r_shift_held            <= 1'b0;
            r_brk_pend              <= 1'b0;
            r_ext_pend              <= 1'b0;
        end else begin
            kbd_data_ready <= 1'b0;
            if (w_byte_vld) begin
                if (r_sreg == SC_BREAK) begin
                    r_brk_pend <= 1'b1;
                end else if (r_sreg == SC_EXT) begin
                    r_ext_pend <= 1'b1;
                end else if (r_brk_pend || r_ext_pend) begin
                    if (r_brk_pend && (r_sreg == SC_LSHIFT || r_sreg == SC_RSHIFT))
                        r_shift_held <= 1'b0;
                    r_brk_pend <= 1'b0;
                    r_ext_pend <= 1'b0;
                end else if (r_sreg == SC_LSHIFT || r_sreg == SC_RSHIFT) begin
                    r_shift_held <= 1'b1;
                end else if (w_lut[8]) begin
                    kbd_data_ready          <= 1'b1;
                    kbd_received_ascii_code <= w_ascii;
                end
            end
        end
    end

endmodule

// File: doc/ps2_kbd_ascii_source.md
PS2_KBD_ASCII_SOURCE -- requirements
Module: ps2_kbd_ascii_source

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, is the number of clk_in cycles with no PS/2 falling edge after which a partial frame is abandoned (1 ms at 50 MHz).
REQ-002 Port clk_in, input, 1, is the 50 MHz system clock; the block SHALL use this single clock only.
REQ-003 Port reset, input, 1, is the asynchronous active-low reset.
REQ-004 Port ps2_clk, input, 1, is the raw PS/2 clock from the keyboard, asynchronous to clk_in.
REQ-005 Port ps2_data, input, 1, is the raw PS/2 data from the keyboard, asynchronous to clk_in.
REQ-006 Port kbd_data_ready, output, 1, is a one-cycle strobe marking a new ASCII character.
REQ-007 Port kbd_received_ascii_code, output, 8, is the decoded ASCII character, held until the next strobe.
REQ-008 Port parity_err, output, 1, is a one-cycle strobe marking a rejected frame.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is detected on the synchronized ps2_clk only.
REQ-010 The frame FSM SHALL have four states: IDLE, DATA, PARITY, STOP; every data sample is taken on a detected falling edge.
REQ-011 In IDLE, sampled data 0 (start bit) SHALL move the FSM to DATA; sampled data 1 SHALL keep it in IDLE.
REQ-012 DATA SHALL shift in 8 bits LSB first, using a 3-bit counter; after bit 7 it moves to PARITY.
REQ-013 PARITY SHALL capture the parity bit; STOP SHALL sample the stop bit and then return to IDLE.
REQ-014 A frame is valid only if the stop bit is 1 and, when parity checking is compiled in, the data bits plus parity bit have odd parity.
REQ-015 A valid byte SHALL reach the decoder exactly one clk_in cycle after the stop-bit edge; kbd_data_ready asserts in that same cycle when the byte maps to ASCII.
REQ-016 If TIMEOUT_CYCLES pass with no falling edge while not in IDLE, the FSM SHALL return to IDLE, discard the partial byte, and assert no strobe.
REQ-017 Decoder, byte 0xF0: set break_pending; no output.
REQ-018 Decoder, byte 0xE0: set ext_pending; no output.
REQ-019 Decoder, the byte that follows a prefix: SHALL be consumed without output; if it is 0x12 or 0x59 with break_pending set, shift SHALL clear; both pending flags then clear.
REQ-020 Decoder, make code 0x12 or 0x59 (left/right shift): shift SHALL set; no output.
REQ-021 Set-2 make codes for a–z, 0–9 and space (0x29) SHALL map to ASCII; letters are 0x41–0x5A when shift is set and 0x61–0x7A otherwise; digits and space ignore shift.
REQ-022 Fixed mappings include 0x24→E/e, 0x23→D/d, 0x32→B/b, 0x2B→F/f, 0x2D→R/r, 0x16→'1', 0x45→'0'.
REQ-023 Unmapped make codes SHALL be dropped silently, with no strobe and no change to kbd_received_ascii_code.
REQ-024 kbd_data_ready and parity_err SHALL never be asserted in the same cycle, and neither SHALL be asserted on two consecutive cycles.
REQ-025 Typematic repeats (repeated make codes) SHALL each produce a strobe.

Reset
REQ-026 Asserting reset (low) SHALL asynchronously clear all outputs to 0, set the FSM to IDLE, clear the shift register, bit counter, timeout counter, shift, break_pending and ext_pending, and set the synchronizer flops to 1.
REQ-027 A reset asserted mid-frame SHALL discard the frame; the first frame after release decodes correctly.

Configuration
REQ-028 With KBD_PARITY_CHECK_EN defined, a frame with bad parity SHALL be dropped and parity_err SHALL pulse for one cycle in the cycle the frame would have been delivered.
REQ-029 Without KBD_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored, and parity_err SHALL be tied to 0.

Structure
REQ-030 A shared package kbd_pkg SHALL hold the frame-state enum, the scan-code constants (0xF0, 0xE0, 0x12, 0x59) and the ASCII character constants.
REQ-031 The synchronizer and falling-edge detector SHALL be a sub-module named ps2_sync_edge; the FSM, decoder and scan-code table stay in the top module.

Verification
REQ-032 Frame for 0x24 with correct parity, shift clear -> one kbd_data_ready pulse, kbd_received_ascii_code = 0x65 ('e').
REQ-033 Frames 0x12, 0x23, F0 0x23, F0 0x12, 0x23 -> strobes carrying 0x44 ('D') then 0x64 ('d'), nothing else.
REQ-034 Frames E0 0x75, then 0x2D -> exactly one strobe, value 0x72 ('r').
REQ-035 Frame 0x32 with a flipped parity bit, KBD_PARITY_CHECK_EN defined -> parity_err pulses once, no kbd_data_ready; without the macro -> strobe with 0x62.
REQ-036 Start bit plus 4 data bits, then ps2_clk idle for TIMEOUT_CYCLES+10 cycles, then a full 0x2B frame -> a single strobe with 0x66 ('f').
REQ-037 Reset pulsed low during bit 5 of a frame, then a full 0x16 frame -> outputs read 0 during reset, then one strobe with 0x31 ('1').
